rps_match_judge: RTL and testbench
==================================

Name: rps_match_judge

Overview:
- Clocked rock-paper-scissors match referee for two players.
- Each player submits a move as a right-justified ASCII string ("ROCK", "PAPER", "SCISSORS") over a valid/ready handshake.
- Judges each round, keeps per-player scores, and declares a match winner at a parametrised target score.
- Sits behind the player front-ends; its status and score outputs feed the display/LED logic.

Parameters:
- NAME_W, 64: move-name bus width in bits (8 ASCII chars); must be ≥64.
- WIN_TARGET, 3: round wins needed to win the match; legal range 1..(2^SCORE_W − 1).
- SCORE_W, 4: width of each score counter.

Ports:
- clk  in  1  clock; all state changes on the rising edge.
- rst_n  in  1  asynchronous active-low reset.
- en  in  1  block enable; 0 freezes all state and forces both ready outputs low.
- new_match  in  1  synchronous single-cycle pulse; clears scores and starts a match.
- p1_name  in  NAME_W  player 1 move, ASCII, zero-padded in the upper bytes.
- p1_valid  in  1  player 1 move offered.
- p1_ready  out  1  player 1 move can be accepted.
- p2_name  in  NAME_W  player 2 move.
- p2_valid  in  1  player 2 move offered.
- p2_ready  out  1  player 2 move can be accepted.
- round_done  out  1  one-cycle pulse when a round result is published.
- round_result  out  2  0 = draw, 1 = player 1 wins, 2 = player 2 wins, 3 = invalid move.
- p1_score  out  SCORE_W  player 1 rounds won.
- p2_score  out  SCORE_W  player 2 rounds won.
- match_over  out  1  high once a player reaches WIN_TARGET.
- winner  out  2  0 = none, 1 = player 1, 2 = player 2.

Behaviour:
- Reset (rst_n = 0, asynchronous):
  - State goes to IDLE.
  - All outputs are 0, including both ready outputs.
  - Both move latches are cleared.
- FSM has four states: IDLE, COLLECT, JUDGE, DONE.
- IDLE:
  - Ready outputs are 0.
  - new_match with en = 1 moves to COLLECT and clears scores, winner, match_over and the latches.
- COLLECT:
  - pX_ready = en && !pX_captured.
  - A move is captured on the edge where pX_valid && pX_ready; that player's ready then drops.
  - Both players may be captured on the same edge.
  - A second offer from an already-captured player stalls until the next round.
  - On the edge after both latches are full, go to JUDGE.
- JUDGE (one cycle):
  - Decode each latched move by full-width compare against the zero-padded ASCII constants "ROCK", "PAPER", "SCISSORS".
  - Any other value, including non-zero upper bytes, is invalid.
  - Rules: ROCK beats SCISSORS, SCISSORS beats PAPER, PAPER beats ROCK; equal moves are a draw.
  - If either move is invalid, result is 3 and no score changes.
  - On the exit edge: register round_result, pulse round_done for exactly one cycle, increment the winner's score, clear both latches.
  - Round latency: round_done rises 2 edges after the capture of the second move.
- Match end:
  - If the incremented score equals WIN_TARGET, set match_over = 1 and winner, and go to DONE.
  - Otherwise return to COLLECT.
  - Scores never exceed WIN_TARGET; there is no wrap.
- DONE:
  - Ready outputs are 0; outputs hold.
  - new_match with en = 1 starts a new match, as from IDLE.
- new_match in COLLECT or JUDGE:
  - Aborts the current round; the latches are discarded.
  - Scores clear and state goes to COLLECT; no round_done pulse.
  - new_match has priority over a same-cycle capture.
- en = 0:
  - No state, latch or score changes; new_match is ignored.
  - round_done is forced to 0.
  - round_result, scores, match_over and winner hold.
- round_result holds its last value until the next JUDGE.

Optional Feature:
- Macro: RPS_CASE_INSENSITIVE_EN.
- When defined: each byte in 0x61–0x7A is mapped to uppercase before the compare, so "rock", "Paper" and "sCiSsOrS" are valid.
- When undefined: only exact uppercase strings are valid; "rock" yields result 3.

Test Plan:
- Reset mid-round: assert rst_n = 0 with p1 captured → all outputs 0 immediately (asynchronous); after release, ready = 0 until new_match.
- Basic round: new_match; p1 = "ROCK" and p2 = "SCISSORS" on the same cycle → round_done 2 edges later, round_result = 1, p1_score = 1, p2_score = 0.
- Staggered handshake: p1 = "PAPER" at cycle 3, p2 = "ROCK" at cycle 7 with p1_valid held high → p1_ready = 0 in cycles 4–7; result 1, single capture of p1.
- Invalid and draw:
  - "LIZARD" vs "ROCK" → result 3, scores unchanged.
  - "PAPER" vs "PAPER" → result 0, scores unchanged.
  - Without the macro, "rock" vs "PAPER" → result 3.
- Match end (WIN_TARGET = 3): p2 wins 3 rounds → match_over = 1, winner = 2, p2_score = 3; further valid offers are not accepted; new_match → scores 0, match_over = 0.
- en gating and abort:
  - en = 0 for 5 cycles during COLLECT → no captures, round_done stays 0, state held.
  - new_match asserted on the same cycle as a p2 capture → latches cleared, no round_done.

Source files
------------

// File: rtl/rps_match_judge_if.sv
// Player/status bundle for the rock-paper-scissors referee.
// master drives moves and control; slave is the referee.
interface rps_match_judge_if #(
   parameter int unsigned NAME_W  = 64,
   parameter int unsigned SCORE_W = 4
);
   logic               en;
   logic               new_match;
   logic [NAME_W-1:0]  p1_name;
   logic               p1_valid;
   logic               p1_ready;
   logic [NAME_W-1:0]  p2_name;
   logic               p2_valid;
   logic               p2_ready;
   logic               round_done;
   logic [1:0]         round_result;
   logic [SCORE_W-1:0] p1_score;
   logic [SCORE_W-1:0] p2_score;
   logic               match_over;
   logic [1:0]         winner;

   modport master (
      output en, new_match, p1_name, p1_valid, p2_name, p2_valid,
      input  p1_ready, p2_ready, round_done, round_result,
             p1_score, p2_score, match_over, winner
   );

   modport slave (
      input  en, new_match, p1_name, p1_valid, p2_name, p2_valid,
      output p1_ready, p2_ready, round_done, round_result,
             p1_score, p2_score, match_over, winner
   );
endinterface

// File: rtl/rps_match_judge.sv
// Two-player rock-paper-scissors referee: collects moves, judges rounds, tracks the match.
// Optional macro RPS_CASE_INSENSITIVE_EN folds lowercase ASCII to uppercase before decoding.
module rps_match_judge #(
   parameter int unsigned NAME_W     = 64,
   parameter int unsigned WIN_TARGET = 3,
   parameter int unsigned SCORE_W    = 4
) (
   input logic              clk,
   input logic              rst_n,
   rps_match_judge_if.slave bus
);

   typedef enum logic [1:0] {ST_IDLE, ST_COLLECT, ST_JUDGE, ST_DONE} state_e;
   typedef enum logic [1:0] {MV_BAD, MV_ROCK, MV_PAPER, MV_SCIS} move_e;

   localparam int unsigned        NAME_BYTES = NAME_W / 8;
   localparam logic [1:0]         RES_DRAW   = 2'd0;
   localparam logic [1:0]         RES_P1     = 2'd1;
   localparam logic [1:0]         RES_P2     = 2'd2;
   localparam logic [1:0]         RES_BAD    = 2'd3;
   localparam logic [SCORE_W-1:0] TARGET_S   = SCORE_W'(WIN_TARGET);
   localparam logic [NAME_W-1:0]  STR_ROCK   = NAME_W'("ROCK");
   localparam logic [NAME_W-1:0]  STR_PAPER  = NAME_W'("PAPER");
   localparam logic [NAME_W-1:0]  STR_SCIS   = NAME_W'("SCISSORS");

   state_e             state_q, state_d;
   logic               p1_cap_q, p1_cap_d, p2_cap_q, p2_cap_d;
   logic [NAME_W-1:0]  p1_lat_q, p1_lat_d, p2_lat_q, p2_lat_d;
   logic               round_done_q, round_done_d;
   logic [1:0]         round_result_q, round_result_d;
   logic [SCORE_W-1:0] p1_score_q, p1_score_d, p2_score_q, p2_score_d;
   logic               match_over_q, match_over_d;
   logic [1:0]         winner_q, winner_d;

   logic  p1_rdy, p2_rdy, p1_take, p2_take;
   move_e mv1, mv2;
   logic [1:0] res;

   // Optional lowercase folding; everything outside a-z passes through untouched.
   function automatic logic [NAME_W-1:0] fold_name(input logic [NAME_W-1:0] s);
      logic [NAME_W-1:0] r;
`ifdef RPS_CASE_INSENSITIVE_EN
      logic [7:0] b;
      r = s;
      for (int i = 0; i < int'(NAME_BYTES); i++) begin
         b = s[i*8 +: 8];
         if (b >= 8'h61 && b <= 8'h7A) r[i*8 +: 8] = b - 8'h20;
      end
`else
      r = s;
`endif
      return r;
   endfunction

   function automatic move_e decode(input logic [NAME_W-1:0] s);
      logic [NAME_W-1:0] u;
      u = fold_name(s);
      if (u == STR_ROCK)  return MV_ROCK;
      if (u == STR_PAPER) return MV_PAPER;
      if (u == STR_SCIS)  return MV_SCIS;
      return MV_BAD;
   endfunction

   function automatic logic [1:0] judge(input move_e a, input move_e b);
      if (a == MV_BAD || b == MV_BAD) return RES_BAD;
      if (a == b)                     return RES_DRAW;
      if ((a == MV_ROCK  && b == MV_SCIS)  ||
          (a == MV_SCIS  && b == MV_PAPER) ||
          (a == MV_PAPER && b == MV_ROCK))  return RES_P1;
      return RES_P2;
   endfunction

   assign p1_rdy  = bus.en && (state_q == ST_COLLECT) && !p1_cap_q;
   assign p2_rdy  = bus.en && (state_q == ST_COLLECT) && !p2_cap_q;
   assign p1_take = bus.p1_valid && p1_rdy;
   assign p2_take = bus.p2_valid && p2_rdy;
   assign mv1     = decode(p1_lat_q);
   assign mv2     = decode(p2_lat_q);
   assign res     = judge(mv1, mv2);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q        <= ST_IDLE;
         p1_cap_q       <= 1'b0;
         p2_cap_q       <= 1'b0;
         p1_lat_q       <= '0;
         p2_lat_q       <= '0;
         round_done_q   <= 1'b0;
         round_result_q <= 2'd0;
         p1_score_q     <= '0;
         p2_score_q     <= '0;
         match_over_q   <= 1'b0;
         winner_q       <= 2'd0;
      end else begin
         state_q        <= state_d;
         p1_cap_q       <= p1_cap_d;
         p2_cap_q       <= p2_cap_d;
         p1_lat_q       <= p1_lat_d;
         p2_lat_q       <= p2_lat_d;
         round_done_q   <= round_done_d;
         round_result_q <= round_result_d;
         p1_score_q     <= p1_score_d;
         p2_score_q     <= p2_score_d;
         match_over_q   <= match_over_d;
         winner_q       <= winner_d;
      end
   end

   // Next state; new_match outranks everything else, en low freezes all.
   always_comb begin
      state_d        = state_q;
      p1_cap_d       = p1_cap_q;
      p2_cap_d       = p2_cap_q;
      p1_lat_d       = p1_lat_q;
      p2_lat_d       = p2_lat_q;
      round_done_d   = 1'b0;
      round_result_d = round_result_q;
      p1_score_d     = p1_score_q;
      p2_score_d     = p2_score_q;
      match_over_d   = match_over_q;
      winner_d       = winner_q;
      if (bus.en) begin
         if (bus.new_match) begin
            state_d      = ST_COLLECT;
            p1_cap_d     = 1'b0;
            p2_cap_d     = 1'b0;
            p1_lat_d     = '0;
            p2_lat_d     = '0;
            p1_score_d   = '0;
            p2_score_d   = '0;
            match_over_d = 1'b0;
            winner_d     = 2'd0;
         end else begin
            case (state_q)
               ST_COLLECT: begin
                  if (p1_cap_q && p2_cap_q) state_d = ST_JUDGE;
                  if (p1_take) begin
                     p1_cap_d = 1'b1;
                     p1_lat_d = bus.p1_name;
                  end
                  if (p2_take) begin
                     p2_cap_d = 1'b1;
                     p2_lat_d = bus.p2_name;
                  end
               end
               ST_JUDGE: begin
                  state_d        = ST_COLLECT;
                  round_result_d = res;
                  round_done_d   = 1'b1;
                  p1_cap_d       = 1'b0;
                  p2_cap_d       = 1'b0;
                  p1_lat_d       = '0;
                  p2_lat_d       = '0;
                  if (res == RES_P1) begin
                     p1_score_d = p1_score_q + SCORE_W'(1);
                     if (p1_score_d == TARGET_S) begin
                        match_over_d = 1'b1;
                        winner_d     = 2'd1;
                        state_d      = ST_DONE;
                     end
                  end else if (res == RES_P2) begin
                     p2_score_d = p2_score_q + SCORE_W'(1);
                     if (p2_score_d == TARGET_S) begin
                        match_over_d = 1'b1;
                        winner_d     = 2'd2;
                        state_d      = ST_DONE;
                     end
                  end
               end
               default: ;
            endcase
         end
      end
   end

   assign bus.p1_ready     = p1_rdy;
   assign bus.p2_ready     = p2_rdy;
   assign bus.round_done   = round_done_q && bus.en;
   assign bus.round_result = round_result_q;
   assign bus.p1_score     = p1_score_q;
   assign bus.p2_score     = p2_score_q;
   assign bus.match_over   = match_over_q;
   assign bus.winner       = winner_q;

endmodule

// File: tb/tb_rps_match_judge.sv
// Directed bench for rps_match_judge: table of judged rounds plus handshake/abort/reset sequences.
module tb_rps_match_judge;
   localparam int unsigned NAME_W  = 64;
   localparam int unsigned SCORE_W = 4;

   logic clk = 1'b0;
   logic rst_n;
   always #5 clk = ~clk;

   rps_match_judge_if #(.NAME_W(NAME_W), .SCORE_W(SCORE_W)) bus ();

   rps_match_judge #(.NAME_W(NAME_W), .WIN_TARGET(3), .SCORE_W(SCORE_W)) dut (
      .clk(clk), .rst_n(rst_n), .bus(bus)
   );

   typedef struct {
      logic [63:0] n1;
      logic [63:0] n2;
      logic [1:0]  res;
   } vec_t;

   vec_t vecs[8];
   int   errors = 0;
   int   checks = 0;
   int   exp_s1 = 0;
   int   exp_s2 = 0;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", nm, act, exp);
      end
   endtask

   task automatic check_state(input string nm);
      chk({nm, " p1_score"}, 32'(bus.p1_score), 32'(exp_s1));
      chk({nm, " p2_score"}, 32'(bus.p2_score), 32'(exp_s2));
      chk({nm, " match_over"}, 32'(bus.match_over), 32'((exp_s1 == 3) || (exp_s2 == 3)));
      chk({nm, " winner"}, 32'(bus.winner), (exp_s1 == 3) ? 32'd1 : (exp_s2 == 3) ? 32'd2 : 32'd0);
   endtask

   // Called on the negedge right after the second capture; round_done expected two negedges later.
   task automatic wait_done(input string nm, input logic [1:0] res);
      int lat = 0;
      while (!bus.round_done && lat < 8) begin
         @(negedge clk);
         lat++;
      end
      chk({nm, " latency"}, 32'(lat), 32'd2);
      chk({nm, " result"}, 32'(bus.round_result), 32'(res));
      if (res == 2'd1) exp_s1++;
      if (res == 2'd2) exp_s2++;
      check_state(nm);
      @(negedge clk);
      chk({nm, " pulse_end"}, 32'(bus.round_done), 32'd0);
   endtask

   task automatic play(input logic [63:0] n1, input logic [63:0] n2, input logic [1:0] res,
                       input string nm);
      @(negedge clk);
      bus.p1_name = n1; bus.p1_valid = 1'b1;
      bus.p2_name = n2; bus.p2_valid = 1'b1;
      #1;
      chk({nm, " p1_ready"}, 32'(bus.p1_ready), 32'd1);
      chk({nm, " p2_ready"}, 32'(bus.p2_ready), 32'd1);
      @(negedge clk);
      bus.p1_valid = 1'b0; bus.p2_valid = 1'b0;
      wait_done(nm, res);
   endtask

   task automatic pulse_new_match();
      @(negedge clk);
      bus.new_match = 1'b1;
      @(negedge clk);
      bus.new_match = 1'b0;
      exp_s1 = 0; exp_s2 = 0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "timeout");
   end

   initial begin
      vecs[0] = '{64'("ROCK"),   64'("SCISSORS"), 2'd1};
      vecs[1] = '{64'("LIZARD"), 64'("ROCK"),     2'd3};
      vecs[2] = '{64'("PAPER"),  64'("PAPER"),    2'd0};
`ifdef RPS_CASE_INSENSITIVE_EN
      vecs[3] = '{64'("rock"),   64'("PAPER"),    2'd2};
`else
      vecs[3] = '{64'("rock"),   64'("PAPER"),    2'd3};
`endif
      vecs[4] = '{64'("SCISSORS"), 64'("PAPER"),  2'd1};
      vecs[5] = '{64'("ROCK"),   64'("PAPER"),    2'd2};
      vecs[6] = '{64'h0100_0000_524F_434B, 64'("ROCK"), 2'd3};
      vecs[7] = '{64'("SCISSORS"), 64'("SCISSORS"), 2'd0};

      rst_n = 1'b0;
      bus.en = 1'b1; bus.new_match = 1'b0;
      bus.p1_name = '0; bus.p1_valid = 1'b0;
      bus.p2_name = '0; bus.p2_valid = 1'b0;
      repeat (2) @(negedge clk);
      chk("reset round_result", 32'(bus.round_result), 32'd0);
      chk("reset p1_ready", 32'(bus.p1_ready), 32'd0);
      check_state("reset");
      rst_n = 1'b1;

      // IDLE never accepts moves
      bus.p1_valid = 1'b1; bus.p2_valid = 1'b1;
      repeat (2) @(negedge clk);
      chk("idle p1_ready", 32'(bus.p1_ready), 32'd0);
      chk("idle p2_ready", 32'(bus.p2_ready), 32'd0);
      bus.p1_valid = 1'b0; bus.p2_valid = 1'b0;

      pulse_new_match();
      for (int i = 0; i < 8; i++) play(vecs[i].n1, vecs[i].n2, vecs[i].res, $sformatf("vec%0d", i));

      // Staggered handshake with p1_valid held across the wait
      pulse_new_match();
      @(negedge clk);
      bus.p1_name = 64'("PAPER"); bus.p1_valid = 1'b1;
      #1 chk("stag p1_ready before", 32'(bus.p1_ready), 32'd1);
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         #1 chk($sformatf("stag p1_ready held %0d", i), 32'(bus.p1_ready), 32'd0);
      end
      chk("stag p2_ready", 32'(bus.p2_ready), 32'd1);
      bus.p2_name = 64'("ROCK"); bus.p2_valid = 1'b1;
      @(negedge clk);
      bus.p2_valid = 1'b0;
      wait_done("stag", 2'd1);
      bus.p1_valid = 1'b0;

      // Match end: p2 wins three rounds
      pulse_new_match();
      for (int i = 0; i < 3; i++) play(64'("ROCK"), 64'("PAPER"), 2'd2, $sformatf("end%0d", i));
      bus.p1_name = 64'("ROCK"); bus.p1_valid = 1'b1;
      bus.p2_name = 64'("PAPER"); bus.p2_valid = 1'b1;
      #1;
      chk("done p1_ready", 32'(bus.p1_ready), 32'd0);
      chk("done p2_ready", 32'(bus.p2_ready), 32'd0);
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         chk($sformatf("done no_round %0d", i), 32'(bus.round_done), 32'd0);
      end
      bus.p1_valid = 1'b0; bus.p2_valid = 1'b0;
      check_state("done hold");
      pulse_new_match();
      check_state("rematch");

      // en low freezes the collector
      @(negedge clk);
      bus.en = 1'b0;
      bus.p1_name = 64'("ROCK"); bus.p1_valid = 1'b1;
      bus.p2_name = 64'("SCISSORS"); bus.p2_valid = 1'b1;
      for (int i = 0; i < 5; i++) begin
         #1;
         chk($sformatf("en0 p1_ready %0d", i), 32'(bus.p1_ready), 32'd0);
         chk($sformatf("en0 round_done %0d", i), 32'(bus.round_done), 32'd0);
         @(negedge clk);
      end
      check_state("en0");
      bus.en = 1'b1;
      #1 chk("en1 p2_ready", 32'(bus.p2_ready), 32'd1);
      @(negedge clk);
      bus.p1_valid = 1'b0; bus.p2_valid = 1'b0;
      wait_done("en1", 2'd1);

      // new_match on the same edge as a p2 capture aborts the round
      @(negedge clk);
      bus.p1_name = 64'("ROCK"); bus.p1_valid = 1'b1;
      @(negedge clk);
      bus.p1_valid = 1'b0;
      #1 chk("abort p1 captured", 32'(bus.p1_ready), 32'd0);
      bus.new_match = 1'b1;
      bus.p2_name = 64'("SCISSORS"); bus.p2_valid = 1'b1;
      @(negedge clk);
      bus.new_match = 1'b0; bus.p2_valid = 1'b0;
      exp_s1 = 0; exp_s2 = 0;
      check_state("abort");
      #1;
      chk("abort p1_ready", 32'(bus.p1_ready), 32'd1);
      chk("abort p2_ready", 32'(bus.p2_ready), 32'd1);
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         chk($sformatf("abort no_round %0d", i), 32'(bus.round_done), 32'd0);
      end
      play(64'("PAPER"), 64'("ROCK"), 2'd1, "post_abort");

      // Asynchronous reset with p1 captured and non-zero outputs
      @(negedge clk);
      bus.p1_name = 64'("ROCK"); bus.p1_valid = 1'b1;
      @(negedge clk);
      bus.p1_valid = 1'b0;
      #2 rst_n = 1'b0;
      #1;
      exp_s1 = 0; exp_s2 = 0;
      chk("async round_result", 32'(bus.round_result), 32'd0);
      chk("async p1_ready", 32'(bus.p1_ready), 32'd0);
      check_state("async");
      @(negedge clk);
      rst_n = 1'b1;
      bus.p1_valid = 1'b1; bus.p2_valid = 1'b1;
      for (int i = 0; i < 2; i++) begin
         @(negedge clk);
         #1;
         chk($sformatf("post_rst p1_ready %0d", i), 32'(bus.p1_ready), 32'd0);
         chk($sformatf("post_rst p2_ready %0d", i), 32'(bus.p2_ready), 32'd0);
      end
      bus.p1_valid = 1'b0; bus.p2_valid = 1'b0;

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
